// File: rtl/cte_pkg.sv
// cte_pkg: slot schedule, group-word layout and types shared by the YUV scheduler
package cte_pkg;
   typedef logic [31:0] grp_t;
   typedef logic [2:0] slot_t;
   typedef enum logic {IDLE, RUN} state_t;
   localparam slot_t SLOT_U  = 3'd0;
   localparam slot_t SLOT_Y1 = 3'd1;
   localparam slot_t SLOT_V  = 3'd2;
   localparam slot_t SLOT_P0 = 3'd3;
   localparam slot_t SLOT_Y2 = 3'd4;
   localparam slot_t SLOT_P1 = 3'd5;
   localparam int OFS_U  = 24;
   localparam int OFS_Y1 = 16;
   localparam int OFS_V  = 8;
   localparam int OFS_Y2 = 0;
   function automatic logic [7:0] grp_byte(grp_t w, int ofs);
      return w[ofs +: 8];
   endfunction
endpackage

// File: rtl/cte_rr_arbiter2.sv
// cte_rr_arbiter2: 2-way round-robin arbiter; last grant advances only when adv is high
module cte_rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);
   logic last;
   always_comb gnt = &req ? (last ? 2'b01 : 2'b10) : req;
   always_ff @(posedge clk)
      if (reset) last <= 1'b1;
      else if (adv && |req) last <= gnt[1];
endmodule

// File: rtl/cte_yuv_scheduler.sv
// cte_yuv_scheduler: round-robin sharing of one YUV-to-RGB converter between two 4:2:2 requesters,
// serialising each group into the converter's 6-slot cadence and tagging the returned pixels
module cte_yuv_scheduler
   import cte_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [31:0]      req_data0,
   input  logic [31:0]      req_data1,
   output logic [1:0]       req_ready,
   output logic             cte_in_en,
   output logic [7:0]       cte_yuv,
   input  logic             cte_out_valid,
   input  logic [23:0]      cte_rgb,
   output logic             out_valid,
   output logic [23:0]      out_rgb,
   output logic             out_id,
   output logic             out_last,
   output logic             busy,
   output logic             seq_err,
   output logic [CNT_W-1:0] grp_cnt
);
   state_t state, state_nx;
   slot_t slot, slot_nx;
   grp_t word;
   logic owner, eval, grant, active, pix_slot;
   logic [1:0] gnt;
   // no grant while in reset so upstream never sees a transfer that gets discarded
   assign eval = !reset && (state == IDLE || slot == SLOT_P1);
   assign grant = eval && |req_valid;
   cte_rr_arbiter2 u_arb (
      .clk  (clk),
      .reset(reset),
      .req  (req_valid),
      .adv  (eval),
      .gnt  (gnt)
   );
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         slot  <= SLOT_U;
      end else begin
         state <= state_nx;
         slot  <= slot_nx;
      end
   always_comb begin
      state_nx = (grant || (state == RUN && slot != SLOT_P1)) ? RUN : IDLE;
      slot_nx  = (state == RUN && slot != SLOT_P1) ? slot_t'(slot + 3'd1) : SLOT_U;
   end
   always_comb begin
      active    = state == RUN;
      pix_slot  = active && (slot == SLOT_P0 || slot == SLOT_P1);
      req_ready = eval ? gnt : 2'b00;
      cte_in_en = active;
      busy      = active;
      cte_yuv   = !active          ? 8'h00 :
                  slot == SLOT_U   ? grp_byte(word, OFS_U) :
                  slot == SLOT_Y1  ? grp_byte(word, OFS_Y1) :
                  slot == SLOT_V   ? grp_byte(word, OFS_V) :
                  slot == SLOT_Y2  ? grp_byte(word, OFS_Y2) : 8'h00;
      out_valid = pix_slot && cte_out_valid;
      out_rgb   = out_valid ? cte_rgb : 24'h0;
      out_id    = owner;
      out_last  = slot == SLOT_P1;
   end
   always_ff @(posedge clk)
      if (reset) begin
         word    <= '0;
         owner   <= 1'b0;
         seq_err <= 1'b0;
         grp_cnt <= '0;
      end else begin
         if (grant) begin
            word  <= gnt[1] ? req_data1 : req_data0;
            owner <= gnt[1];
         end
         if (cte_out_valid != pix_slot) seq_err <= 1'b1;
         if (active && slot == SLOT_P1 && cte_out_valid) grp_cnt <= grp_cnt + CNT_W'(1);
      end
endmodule

// File: tb/tb_cte_yuv_scheduler.sv
// tb_cte_yuv_scheduler: directed scoreboard bench with a behavioural 6-slot YUV converter model
module tb_cte_yuv_scheduler;
   logic clk = 0, reset = 1, force_err = 0;
   logic [1:0] req_valid = 0, req_ready;
   logic [31:0] req_data0 = 0, req_data1 = 0;
   logic cte_in_en, cte_out_valid, out_valid, out_id, out_last, busy, seq_err;
   logic [7:0] cte_yuv;
   logic [23:0] cte_rgb, out_rgb;
   logic [15:0] grp_cnt;
   int cyc = 0, ncmp = 0, nerr = 0;
   typedef struct {logic [23:0] rgb; logic id; logic last; int cyc;} exp_t;
   exp_t sb[$];

   cte_yuv_scheduler #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
      .req_ready(req_ready), .cte_in_en(cte_in_en), .cte_yuv(cte_yuv), .cte_out_valid(cte_out_valid),
      .cte_rgb(cte_rgb), .out_valid(out_valid), .out_rgb(out_rgb), .out_id(out_id), .out_last(out_last),
      .busy(busy), .seq_err(seq_err), .grp_cnt(grp_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // converter model: signed chroma, pixels presented in slots 3 and 5
   logic [2:0] m_slot;
   logic [7:0] m_u, m_y1, m_v, m_y2;
   always @(posedge clk)
      if (reset) m_slot <= 0;
      else if (cte_in_en) begin
         case (m_slot)
            3'd0: m_u <= cte_yuv;
            3'd1: m_y1 <= cte_yuv;
            3'd2: m_v <= cte_yuv;
            3'd4: m_y2 <= cte_yuv;
            default: ;
         endcase
         m_slot <= (m_slot == 3'd5) ? 3'd0 : m_slot + 3'd1;
      end
   function automatic logic [7:0] clamp(int x);
      return (x < 0) ? 8'd0 : (x > 255) ? 8'd255 : 8'(x);
   endfunction
   function automatic logic [23:0] conv(logic [7:0] y, logic [7:0] u, logic [7:0] v);
      int yi, su, sv;
      yi = int'(y);
      su = int'($signed(u));
      sv = int'($signed(v));
      return {clamp(yi + sv + (sv >>> 1)), clamp(yi - ((su + 3 * sv) >>> 2)), clamp(yi + su + (su >>> 1))};
   endfunction
   assign cte_out_valid = cte_in_en && (m_slot == 3'd3 || m_slot == 3'd5 || (force_err && m_slot == 3'd2));
   assign cte_rgb = conv(m_slot == 3'd5 ? m_y2 : m_y1, m_u, m_v);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      ncmp++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk)
      if (out_valid) begin
         if (sb.size() == 0) chk("unexpected_pixel", out_valid, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("pixel", {out_rgb, out_id, out_last}, {e.rgb, e.id, e.last});
            chk("pixel_cycle", cyc, e.cyc);
         end
      end

   task automatic grant_wait(input int id, input logic [23:0] p0, input logic [23:0] p1);
      bit ok = 0;
      for (int n = 0; n < 30; n++) begin
         if (req_ready[id]) begin ok = 1; break; end
         @(negedge clk); #1;
      end
      chk("grant_seen", ok, 1);
      if (ok) begin
         sb.push_back('{p0, id[0], 1'b0, cyc + 4});
         sb.push_back('{p1, id[0], 1'b1, cyc + 6});
      end
   endtask

   task automatic send(input int id, input logic [31:0] d, input logic [23:0] p0, input logic [23:0] p1);
      @(negedge clk); #1;
      if (id == 1) req_data1 = d; else req_data0 = d;
      req_valid[id] = 1'b1;
      #1;
      grant_wait(id, p0, p1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      if (id == 1) req_data1 = ~d; else req_data0 = ~d;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      @(negedge clk); #1;
      for (int n = 0; n < 40; n++) begin
         if (!busy) begin ok = 1; break; end
         @(negedge clk); #1;
      end
      chk("idle_reached", ok, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      sb.delete();
      @(negedge clk);
      reset = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int drops, prev;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {req_ready, cte_in_en, cte_yuv, out_valid, out_rgb, out_id, out_last, busy, seq_err, grp_cnt}, 0);
      reset = 0;
      send(0, 32'h00800040, 24'h808080, 24'h404040);
      wait_idle();
      chk("grp_cnt_1", grp_cnt, 1);
      send(1, 32'h7FFF7FFF, 24'hFF80FF, 24'hFF80FF);
      wait_idle();
      chk("sat_no_seq_err", seq_err, 0);
      send(0, 32'h00008020, 24'h006000, 24'h008020);
      wait_idle();
      chk("grp_cnt_3", grp_cnt, 3);
      // both requesters held valid: four back-to-back alternating groups
      do_reset();
      @(negedge clk); #1;
      req_data0 = 32'h00100020;
      req_data1 = 32'h00300040;
      req_valid = 2'b11;
      #1;
      drops = 0;
      prev = 0;
      for (int g = 0; g < 4; g++) begin
         bit ok = 0;
         for (int n = 0; n < 30; n++) begin
            if (|req_ready) begin ok = 1; break; end
            if (g > 0 && !cte_in_en) drops++;
            @(negedge clk); #1;
         end
         chk("burst_grant_seen", ok, 1);
         chk("burst_owner", req_ready, (g % 2) ? 2'b10 : 2'b01);
         if (g % 2) begin
            sb.push_back('{24'h303030, 1'b1, 1'b0, cyc + 4});
            sb.push_back('{24'h404040, 1'b1, 1'b1, cyc + 6});
         end else begin
            sb.push_back('{24'h101010, 1'b0, 1'b0, cyc + 4});
            sb.push_back('{24'h202020, 1'b0, 1'b1, cyc + 6});
         end
         if (g > 0) chk("burst_period", cyc - prev, 6);
         prev = cyc;
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      chk("burst_in_en_held", drops, 0);
      wait_idle();
      chk("grp_cnt_4", grp_cnt, 4);
      // reset in slot 2 of an in-flight group
      do_reset();
      @(negedge clk); #1;
      req_data0 = 32'h00500060;
      req_valid[0] = 1'b1;
      #1;
      grant_wait(0, 24'h505050, 24'h606060);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1;
      sb.delete();
      @(negedge clk); #1;
      chk("rst_in_en", {cte_in_en, busy}, 0);
      reset = 0;
      repeat (10) @(negedge clk);
      chk("rst_grp_cnt", grp_cnt, 0);
      #1;
      req_data0 = 32'h00110022;
      req_data1 = 32'h00330044;
      req_valid = 2'b11;
      #1;
      chk("rst_prio_req0", req_ready, 2'b01);
      grant_wait(0, 24'h111111, 24'h222222);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      req_data0 = 32'hDEADBEEF;
      @(negedge clk); #1;
      grant_wait(1, 24'h333333, 24'h444444);
      @(posedge clk); #1;
      req_valid = 2'b00;
      req_data1 = 32'hDEADBEEF;
      wait_idle();
      chk("rst_grp_cnt_2", grp_cnt, 2);
      // converter asserting valid in slot 2
      chk("seq_err_clear", seq_err, 0);
      force_err = 1;
      send(0, 32'h00800040, 24'h808080, 24'h404040);
      wait_idle();
      force_err = 0;
      chk("seq_err_set", seq_err, 1);
      send(1, 32'h00800040, 24'h808080, 24'h404040);
      wait_idle();
      chk("seq_err_sticky", seq_err, 1);
      do_reset();
      @(negedge clk); #1;
      chk("seq_err_reset", seq_err, 0);
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
